sel_encoder: RTL and testbench



---
 rtl/sel_encoder_pkg.sv | 21 ++
 rtl/sel_classify.sv | 31 +++
 rtl/sel_encoder.sv | 133 +++++++++++++
 tb/tb_sel_encoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_encoder_pkg.sv
// Shared types and constants for the byte-select encoder.
// Imported by sel_classify and sel_encoder.
package sel_encoder_pkg;

    localparam int SEL_W  = 4;
    localparam int ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } sel_class_t;

endpackage

// File: rtl/sel_classify.sv
// Combinational classifier for the active-low byte selects.
// Reports NONE/ONE/MULTI and, for ONE, the index of the asserted select.
module sel_classify
    import sel_encoder_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_n,
    output sel_class_t        cls,
    output logic [ADDR_W-1:0] idx
);

    logic [2:0] zeros;

    // idx ends up holding the highest low bit; only meaningful when a single bit is low
    always_comb begin
        zeros = 3'd0;
        idx   = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (!sel_n[i]) begin
                zeros = zeros + 3'd1;
                idx   = ADDR_W'(i);
            end
        end
        if (zeros == 3'd0)
            cls = NONE;
        else if (zeros == 3'd1)
            cls = ONE;
        else
            cls = MULTI;
    end

endmodule

// File: rtl/sel_encoder.sv
// Registered 4-to-2 select encoder with stability filter and multi-select fault flag.
// Define SEL_ENCODER_ERRCNT_EN to add the saturating err_cnt fault counter.
module sel_encoder
    import sel_encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sel_n,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              lock_pulse,
    output logic              multi_err
`ifdef SEL_ENCODER_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    sel_class_t        cls;
    logic [ADDR_W-1:0] idx;

    state_t            state, next_state;
    logic [ADDR_W-1:0] cand, next_cand;
    logic [3:0]        scnt, next_scnt;
    logic              load_addr;
    logic              restart;

    sel_classify u_classify (
        .sel_n (sel_n),
        .cls   (cls),
        .idx   (idx)
    );

    // A fresh single select seen outside SETTLE restarts the filter (or locks at once when no filtering is asked for)
    always_comb begin
        next_state = state;
        next_cand  = cand;
        next_scnt  = scnt;
        load_addr  = 1'b0;
        restart    = 1'b0;

        case (state)
            IDLE: begin
                if (cls == ONE)
                    restart = 1'b1;
                else if (cls == MULTI)
                    next_state = FAULT;
            end
            SETTLE: begin
                if (cls == ONE) begin
                    if (idx == cand) begin
                        next_scnt = scnt + 4'd1;
                        if (({1'b0, scnt} + 5'd1) == 5'(STABLE_CYCLES)) begin
                            next_state = LOCKED;
                            load_addr  = 1'b1;
                        end
                    end else begin
                        next_cand = idx;
                        next_scnt = 4'd1;
                    end
                end else if (cls == NONE) begin
                    next_state = IDLE;
                end else begin
                    next_state = FAULT;
                end
            end
            LOCKED: begin
                if (cls == ONE) begin
                    if (idx != addr)
                        restart = 1'b1;
                end else if (cls == NONE) begin
                    next_state = IDLE;
                end else begin
                    next_state = FAULT;
                end
            end
            FAULT: begin
                if (cls == ONE)
                    restart = 1'b1;
                else if (cls == NONE)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (restart) begin
            if (STABLE_CYCLES == 1) begin
                next_state = LOCKED;
                load_addr  = 1'b1;
            end else begin
                next_state = SETTLE;
                next_cand  = idx;
                next_scnt  = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= '0;
            scnt       <= '0;
            addr       <= '0;
            valid      <= 1'b0;
            lock_pulse <= 1'b0;
            multi_err  <= 1'b0;
        end else begin
            state      <= next_state;
            cand       <= next_cand;
            scnt       <= next_scnt;
            valid      <= (next_state == LOCKED);
            lock_pulse <= load_addr;
            multi_err  <= (next_state == FAULT);
            if (load_addr)
                addr <= idx;
        end
    end

`ifdef SEL_ENCODER_ERRCNT_EN
    // Counts entries into FAULT only; dwelling in FAULT does not add
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if ((next_state == FAULT) && (state != FAULT) && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_sel_encoder.sv
// Scoreboard bench for sel_encoder: three instances (STABLE_CYCLES 1, 2, 3) share stimulus.
// Builds with or without SEL_ENCODER_ERRCNT_EN.
module tb_sel_encoder;

    typedef struct packed {
        logic [1:0] addr;
        logic       valid;
        logic       lock_pulse;
        logic       multi_err;
        logic [7:0] err_cnt;
    } out_t;

    typedef struct {
        int         st;
        int         cand;
        int         scnt;
        logic [1:0] addr;
        logic       valid;
        logic       lp;
        logic       merr;
        int         ecnt;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sel_n;

    logic [1:0] addr0, addr1, addr2;
    logic       valid0, valid1, valid2;
    logic       lp0, lp1, lp2;
    logic       me0, me1, me2;
    logic [1:0] ec0;
    logic [7:0] ec1;
    logic [3:0] ec2;

    out_t obs [3];
    out_t exp_q [$];
    mdl_t mdl [3];
    int   stab [3] = '{1, 2, 3};
    int   emax [3] = '{3, 255, 15};
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    sel_encoder #(.STABLE_CYCLES(1), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .sel_n(sel_n), .addr(addr0), .valid(valid0),
        .lock_pulse(lp0), .multi_err(me0)
`ifdef SEL_ENCODER_ERRCNT_EN
        , .err_cnt(ec0)
`endif
    );

    sel_encoder #(.STABLE_CYCLES(2), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .sel_n(sel_n), .addr(addr1), .valid(valid1),
        .lock_pulse(lp1), .multi_err(me1)
`ifdef SEL_ENCODER_ERRCNT_EN
        , .err_cnt(ec1)
`endif
    );

    sel_encoder #(.STABLE_CYCLES(3), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .sel_n(sel_n), .addr(addr2), .valid(valid2),
        .lock_pulse(lp2), .multi_err(me2)
`ifdef SEL_ENCODER_ERRCNT_EN
        , .err_cnt(ec2)
`endif
    );

`ifndef SEL_ENCODER_ERRCNT_EN
    assign ec0 = '0;
    assign ec1 = '0;
    assign ec2 = '0;
`endif

    always_comb begin
        obs[0] = '{addr: addr0, valid: valid0, lock_pulse: lp0, multi_err: me0, err_cnt: 8'(ec0)};
        obs[1] = '{addr: addr1, valid: valid1, lock_pulse: lp1, multi_err: me1, err_cnt: ec1};
        obs[2] = '{addr: addr2, valid: valid2, lock_pulse: lp2, multi_err: me2, err_cnt: 8'(ec2)};
    end

    // Behavioural reference; st codes 0 IDLE, 1 SETTLE, 2 LOCKED, 3 FAULT
    function automatic mdl_t mdl_step(mdl_t m, logic [3:0] s, logic r, int stable, int max_e);
        mdl_t n;
        int   lows;
        int   pos;
        logic lock;
        n    = m;
        lows = $countones(~s);
        pos  = 0;
        lock = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!s[i]) pos = i;
        if (r) begin
            n = '{st: 0, cand: 0, scnt: 0, addr: 2'd0, valid: 1'b0, lp: 1'b0, merr: 1'b0, ecnt: 0};
            return n;
        end
        n.lp = 1'b0;
        if (lows >= 2) begin
            if (m.st != 3 && m.ecnt < max_e) n.ecnt = m.ecnt + 1;
            n.st = 3;
        end else if (lows == 0) begin
            n.st = 0;
        end else if (m.st == 2 && pos == int'(m.addr)) begin
            n.st = 2;
        end else if (m.st == 1 && pos == m.cand) begin
            n.scnt = m.scnt + 1;
            if (n.scnt == stable) lock = 1'b1;
        end else if (m.st == 1) begin
            n.cand = pos;
            n.scnt = 1;
        end else if (stable == 1) begin
            lock = 1'b1;
        end else begin
            n.st   = 1;
            n.cand = pos;
            n.scnt = 1;
        end
        if (lock) begin
            n.st   = 2;
            n.addr = 2'(pos);
            n.lp   = 1'b1;
        end
        n.valid = (n.st == 2);
        n.merr  = (n.st == 3);
        return n;
    endfunction

    task automatic drive_cycle(input logic [3:0] s, input logic r);
        out_t e;
        @(negedge clk);
        sel_n = s;
        rst   = r;
        for (int d = 0; d < 3; d++) begin
            mdl[d] = mdl_step(mdl[d], s, r, stab[d], emax[d]);
            e.addr       = mdl[d].addr;
            e.valid      = mdl[d].valid;
            e.lock_pulse = mdl[d].lp;
            e.multi_err  = mdl[d].merr;
`ifdef SEL_ENCODER_ERRCNT_EN
            e.err_cnt    = 8'(mdl[d].ecnt);
`else
            e.err_cnt    = 8'd0;
`endif
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        out_t e;
        for (int k = 0; k < 6; k++) begin
            drive_cycle(4'b1011, k < 2);
            for (int d = 0; d < 3; d++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL reset dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                end
            end
            if (k == 3) begin
                checks++;
                if (!(valid1 === 1'b1 && addr1 === 2'b10 && lp1 === 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL reset_lock2 cyc%0d: got v%b a%b p%b required v1 a10 p1", cyc, valid1, addr1, lp1);
                end
            end
            if (k == 4) begin
                checks++;
                if (lp1 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_pulse_width cyc%0d: got %b required 0", cyc, lp1);
                end
            end
        end
    endtask

    task automatic test_stability();
        logic [3:0] seq [10] = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF};
        out_t e;
        for (int k = 0; k < 10; k++) begin
            drive_cycle(seq[k], 1'b0);
            for (int d = 0; d < 3; d++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL stability dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                end
            end
        end
    endtask

    task automatic test_select_change();
        logic [3:0] seq [9] = '{4'h7, 4'h7, 4'h7, 4'h7, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
        out_t e;
        for (int k = 0; k < 9; k++) begin
            drive_cycle(seq[k], 1'b0);
            for (int d = 0; d < 3; d++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL select_change dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                end
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0] seq [10] = '{4'h7, 4'h7, 4'h7, 4'hC, 4'hC, 4'hC, 4'hC, 4'hF, 4'hF, 4'hF};
        out_t e;
        for (int k = 0; k < 10; k++) begin
            drive_cycle(seq[k], 1'b0);
            for (int d = 0; d < 3; d++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL multi dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                end
            end
        end
    endtask

    task automatic test_saturation();
        out_t e;
        for (int k = 0; k < 11; k++) begin
            drive_cycle((k % 2 == 0 && k < 10) ? 4'hC : 4'hF, 1'b0);
            for (int d = 0; d < 3; d++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL saturation dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                end
            end
        end
`ifdef SEL_ENCODER_ERRCNT_EN
        checks++;
        if (ec0 !== 2'd3) begin
            errors++;
            $display("[TB] FAIL sat_value: got %0d required 3", ec0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq [11] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hC, 4'hC, 4'hB, 4'hB, 4'hB, 4'hB};
        logic       rs  [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        out_t e;
        for (int k = 0; k < 11; k++) begin
            drive_cycle(seq[k], rs[k]);
            for (int d = 0; d < 3; d++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL reset_mid dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] s;
        int         hold;
        out_t       e;
        for (int k = 0; k < 40; k++) begin
            s    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                drive_cycle(s, ($urandom_range(0, 24) == 0));
                for (int d = 0; d < 3; d++) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (obs[d] !== e) begin
                        errors++;
                        $display("[TB] FAIL back_to_back dut%0d cyc%0d: got %h required %h", d, cyc, obs[d], e);
                    end
                end
            end
        end
    endtask

    initial begin
        sel_n = 4'hF;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++)
            mdl[d] = '{st: 0, cand: 0, scnt: 0, addr: 2'd0, valid: 1'b0, lp: 1'b0, merr: 1'b0, ecnt: 0};
        $display("[TB] starting sel_encoder bench");
        test_reset();
        test_stability();
        test_select_change();
        test_multi();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
